// File: rtl/four_bit_mux_arbiter.sv
// ---------------------------------------------------------------------------
// four_bit_mux_arbiter
//   Two-requester round-robin arbiter driving a shared registered mux.
//   A granted requester's data is captured into Out and held until the
//   consumer accepts it. When a word is accepted, the other requester can be
//   granted on that same edge, so back-to-back service has no idle cycle.
//
// Ports
//   Clk, Reset_n     rising-edge clock, asynchronous active-low reset
//   Req_0 / In_0     requester 0 request and data
//   Req_1 / In_1     requester 1 request and data
//   Out_Ready        consumer accepts Out this cycle
//   Ack_0 / Ack_1    combinational: the word of requester x is accepted now
//   Select           registered mux select (current or last grant)
//   Out, Out_Valid   captured word and its valid flag
//   Last_Grant       round-robin pointer (index of most recent grant)
// ---------------------------------------------------------------------------
module four_bit_mux_arbiter #(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  Req_0,
   input  logic [DATA_WIDTH-1:0] In_0,
   input  logic                  Req_1,
   input  logic [DATA_WIDTH-1:0] In_1,
   input  logic                  Out_Ready,
   output logic                  Ack_0,
   output logic                  Ack_1,
   output logic                  Select,
   output logic [DATA_WIDTH-1:0] Out,
   output logic                  Out_Valid,
   output logic                  Last_Grant
);

   typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] out_q;
   logic                  select_q;
   logic                  last_grant_q;

   logic                  xfer;
   logic                  decide;
   logic                  elig_0, elig_1;
   logic                  grant_en;
   logic                  grant_idx;

   // A grant decision happens in IDLE and on every transfer edge. The
   // requester being acknowledged is masked out so a single continuous
   // requester alternates BUSY/IDLE instead of hogging the mux.
   always_comb begin
      xfer      = (state_q != IDLE) && Out_Ready;
      decide    = (state_q == IDLE) || xfer;
      elig_0    = Req_0 && (state_q != BUSY0);
      elig_1    = Req_1 && (state_q != BUSY1);
      grant_en  = 1'b0;
      grant_idx = 1'b0;
      state_d   = state_q;

      if (decide) begin
         state_d = IDLE;
         if (elig_0 && elig_1) begin
            grant_en  = 1'b1;
            grant_idx = ~last_grant_q;
         end else if (elig_0) begin
            grant_en  = 1'b1;
            grant_idx = 1'b0;
         end else if (elig_1) begin
            grant_en  = 1'b1;
            grant_idx = 1'b1;
         end
         if (grant_en) state_d = grant_idx ? BUSY1 : BUSY0;
      end
   end

   // Last_Grant resets to 1 so the first tie after reset favours requester 0.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= IDLE;
         out_q        <= '0;
         select_q     <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q <= state_d;
         if (grant_en) begin
            out_q        <= grant_idx ? In_1 : In_0;
            select_q     <= grant_idx;
            last_grant_q <= grant_idx;
         end
      end
   end

   assign Ack_0      = (state_q == BUSY0) && Out_Ready;
   assign Ack_1      = (state_q == BUSY1) && Out_Ready;
   assign Out_Valid  = (state_q != IDLE);
   assign Out        = out_q;
   assign Select     = select_q;
   assign Last_Grant = last_grant_q;

endmodule

// File: tb/tb_four_bit_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_four_bit_mux_arbiter
//   Directed vector table with hand-computed expectations. Each row drives
//   inputs on the falling edge; Acks are checked just after (they reflect the
//   state before the next rising edge), registered outputs just after the
//   rising edge. Hand-written sequences follow for exhaustive data and
//   asynchronous reset.
// ---------------------------------------------------------------------------
module tb_four_bit_mux_arbiter;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       Req_0 = 1'b0, Req_1 = 1'b0, Out_Ready = 1'b0;
   logic [3:0] In_0 = '0, In_1 = '0;
   logic       Ack_0, Ack_1, Select, Out_Valid, Last_Grant;
   logic [3:0] Out;

   int n_cmp = 0;
   int n_bad = 0;

   four_bit_mux_arbiter #(.DATA_WIDTH(4)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .Req_0(Req_0), .In_0(In_0), .Req_1(Req_1), .In_1(In_1),
      .Out_Ready(Out_Ready),
      .Ack_0(Ack_0), .Ack_1(Ack_1), .Select(Select), .Out(Out),
      .Out_Valid(Out_Valid), .Last_Grant(Last_Grant)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic       rst_n, req0, req1;
      logic [3:0] in0, in1;
      logic       rdy;
      logic       ack0, ack1;   // expected before the edge
      logic       vld;          // expected after the edge
      logic [3:0] out;
      logic       sel, lg;
   } vec_t;

   localparam int NV = 28;
   vec_t tbl [NV];

   function automatic vec_t v(logic rst_n, logic req0, logic req1,
                              logic [3:0] in0, logic [3:0] in1, logic rdy,
                              logic ack0, logic ack1, logic vld,
                              logic [3:0] out, logic sel, logic lg);
      v = '{rst_n, req0, req1, in0, in1, rdy, ack0, ack1, vld, out, sel, lg};
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      //            rst r0 r1 in0   in1   rdy a0 a1 vld out   sel lg
      tbl[0]  = v(0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 1); // reset
      tbl[1]  = v(1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 1); // release, idle
      tbl[2]  = v(1, 1, 1, 4'hA, 4'h5, 1, 0, 0, 1, 4'hA, 0, 0); // tie -> 0
      tbl[3]  = v(1, 1, 1, 4'hA, 4'h5, 1, 1, 0, 1, 4'h5, 1, 1); // back-to-back 1
      tbl[4]  = v(1, 1, 1, 4'hA, 4'h5, 1, 0, 1, 1, 4'hA, 0, 0);
      tbl[5]  = v(1, 1, 1, 4'hA, 4'h5, 1, 1, 0, 1, 4'h5, 1, 1);
      tbl[6]  = v(1, 0, 1, 4'hA, 4'h3, 1, 0, 1, 0, 4'h5, 1, 1); // req1 masked
      tbl[7]  = v(1, 0, 1, 4'hA, 4'h3, 1, 0, 0, 1, 4'h3, 1, 1); // single req1
      tbl[8]  = v(1, 0, 1, 4'hA, 4'h3, 1, 0, 1, 0, 4'h3, 1, 1);
      tbl[9]  = v(1, 0, 1, 4'hA, 4'h3, 1, 0, 0, 1, 4'h3, 1, 1);
      tbl[10] = v(1, 0, 1, 4'hA, 4'h3, 1, 0, 1, 0, 4'h3, 1, 1);
      tbl[11] = v(1, 1, 0, 4'hC, 4'h3, 0, 0, 0, 1, 4'hC, 0, 0); // grant C, stall
      tbl[12] = v(1, 1, 0, 4'h1, 4'h3, 0, 0, 0, 1, 4'hC, 0, 0); // In_0 changes
      tbl[13] = v(1, 1, 0, 4'h1, 4'h3, 0, 0, 0, 1, 4'hC, 0, 0);
      tbl[14] = v(1, 1, 0, 4'h1, 4'h3, 0, 0, 0, 1, 4'hC, 0, 0);
      tbl[15] = v(1, 1, 0, 4'h1, 4'h3, 0, 0, 0, 1, 4'hC, 0, 0);
      tbl[16] = v(1, 0, 0, 4'h1, 4'h3, 1, 1, 0, 0, 4'hC, 0, 0); // accepted
      tbl[17] = v(1, 0, 0, 4'h1, 4'h3, 1, 0, 0, 0, 4'hC, 0, 0); // single pulse
      tbl[18] = v(1, 1, 0, 4'h7, 4'h3, 0, 0, 0, 1, 4'h7, 0, 0); // grant 7
      tbl[19] = v(1, 0, 0, 4'h7, 4'h3, 0, 0, 0, 1, 4'h7, 0, 0); // withdrawn
      tbl[20] = v(1, 0, 0, 4'h7, 4'h3, 0, 0, 0, 1, 4'h7, 0, 0);
      tbl[21] = v(1, 0, 0, 4'h7, 4'h3, 1, 1, 0, 0, 4'h7, 0, 0); // still acked
      tbl[22] = v(1, 0, 0, 4'h7, 4'h3, 1, 0, 0, 0, 4'h7, 0, 0); // idle ignores rdy
      tbl[23] = v(1, 0, 1, 4'h7, 4'h9, 0, 0, 0, 1, 4'h9, 1, 1); // BUSY1
      tbl[24] = v(0, 0, 1, 4'h7, 4'h9, 1, 0, 0, 0, 4'h0, 0, 1); // reset mid-xfer
      tbl[25] = v(1, 0, 0, 4'h7, 4'h9, 0, 0, 0, 0, 4'h0, 0, 1); // release
      tbl[26] = v(1, 1, 1, 4'h2, 4'hE, 0, 0, 0, 1, 4'h2, 0, 0); // tie -> 0 first
      tbl[27] = v(1, 1, 1, 4'h2, 4'hE, 1, 1, 0, 1, 4'hE, 1, 1);

      for (int i = 0; i < NV; i++) begin
         @(negedge Clk);
         Reset_n   = tbl[i].rst_n;
         Req_0     = tbl[i].req0;
         Req_1     = tbl[i].req1;
         In_0      = tbl[i].in0;
         In_1      = tbl[i].in1;
         Out_Ready = tbl[i].rdy;
         #1;
         chk($sformatf("v%0d ack0", i), {7'd0, Ack_0}, {7'd0, tbl[i].ack0});
         chk($sformatf("v%0d ack1", i), {7'd0, Ack_1}, {7'd0, tbl[i].ack1});
         @(posedge Clk);
         #1;
         chk($sformatf("v%0d valid", i), {7'd0, Out_Valid},  {7'd0, tbl[i].vld});
         chk($sformatf("v%0d out", i),   {4'd0, Out},        {4'd0, tbl[i].out});
         chk($sformatf("v%0d select", i),{7'd0, Select},     {7'd0, tbl[i].sel});
         chk($sformatf("v%0d lastgnt", i),{7'd0, Last_Grant},{7'd0, tbl[i].lg});
      end

      // Exhaustive data: continuous tie with Out_Ready high alternates
      // grants 0,1,0,1 from a fresh reset; each pair gets one edge per side.
      @(negedge Clk);
      Reset_n = 1'b0; Req_0 = 1'b0; Req_1 = 1'b0; Out_Ready = 1'b1;
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int s = 0; s < 2; s++) begin
               @(negedge Clk);
               Req_0 = 1'b1; Req_1 = 1'b1;
               In_0 = 4'(a); In_1 = 4'(b);
               @(posedge Clk);
               #1;
               chk($sformatf("exh %0h/%0h side%0d out", a, b, s),
                   {4'd0, Out}, {4'd0, (s == 0) ? 4'(a) : 4'(b)});
               chk($sformatf("exh %0h/%0h side%0d sel", a, b, s),
                   {7'd0, Select}, {7'd0, s[0]});
            end
         end
      end

      // Asynchronous reset: last exhaustive grant left BUSY1 with Out_Ready
      // high; assert reset between edges and check without any clock edge.
      @(negedge Clk);
      chk("pre-reset ack1", {7'd0, Ack_1}, 8'd1);
      Reset_n = 1'b0;
      #1;
      chk("async valid",   {7'd0, Out_Valid},  8'd0);
      chk("async out",     {4'd0, Out},        8'd0);
      chk("async select",  {7'd0, Select},     8'd0);
      chk("async lastgnt", {7'd0, Last_Grant}, 8'd1);
      chk("async ack1",    {7'd0, Ack_1},      8'd0);
      chk("async ack0",    {7'd0, Ack_0},      8'd0);
      @(negedge Clk);
      Reset_n = 1'b1; Req_0 = 1'b0; Req_1 = 1'b0;
      @(posedge Clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/four_bit_mux_arbiter.md
FOUR_BIT_MUX_ARBITER -- requirements
Module: four_bit_mux_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 4, width of each requester data bus and of Out.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
REQ-003 Clk  input  1  rising-edge clock.
REQ-004 Reset_n  input  1  asynchronous active-low reset.
REQ-005 Req_0  input  1  requester 0 requests the shared mux.
REQ-006 In_0  input  DATA_WIDTH  requester 0 data.
REQ-007 Req_1  input  1  requester 1 requests the shared mux.
REQ-008 In_1  input  DATA_WIDTH  requester 1 data.
REQ-009 Out_Ready  input  1  consumer accepts Out this cycle.
REQ-010 Ack_0  output  1  requester 0 transfer completed this cycle.
REQ-011 Ack_1  output  1  requester 1 transfer completed this cycle.
REQ-012 Select  output  1  registered index of the current or last grant (mux select).
REQ-013 Out  output  DATA_WIDTH  registered captured data.
REQ-014 Out_Valid  output  1  Out holds an untransferred word.
REQ-015 Last_Grant  output  1  index of the most recent grant (round-robin pointer).

Function
REQ-016 FSM SHALL have three states: IDLE, BUSY0, BUSY1; Out_Valid = 1 exactly in BUSY0/BUSY1.
REQ-017 Grant decision (made at a rising edge when state is IDLE, or at a transfer edge) SHALL be: only one eligible requester -> grant it; both eligible -> grant index != Last_Grant; none -> IDLE.
REQ-018 On grant of x: next state BUSYx, Out <= In_x, Select <= x, Last_Grant <= x, all on the same edge.
REQ-019 Latency: Req_x sampled high in IDLE at edge N -> Out_Valid = 1 and Out = In_x from edge N onward (one cycle after request presented).
REQ-020 In BUSYx, Out, Select and Last_Grant SHALL remain stable until transfer; changes on In_0/In_1 SHALL be ignored.
REQ-021 Transfer SHALL occur at an edge where state is BUSYx and Out_Ready = 1.
REQ-022 Ack_x SHALL be combinational: Ack_x = (state == BUSYx) AND Out_Ready; at most one Ack high per cycle; both 0 in IDLE.
REQ-023 At the transfer edge, the acknowledged requester SHALL be treated as not requesting; if the other requester has Req high, it SHALL be granted on that same edge (back-to-back, no IDLE bubble); otherwise next state IDLE.
REQ-024 Consequently, a single requester holding Req continuously SHALL be served every second cycle at most (BUSY, IDLE, BUSY, ...).
REQ-025 In IDLE, Out and Select SHALL hold their last values; Out_Ready SHALL be ignored.
REQ-026 Req_x deasserted while BUSYx SHALL NOT cancel the transfer; the captured word remains valid until Out_Ready.
REQ-027 Out_Ready held low SHALL stall indefinitely in BUSYx with no Ack and no state change.

Reset
REQ-028 While Reset_n = 0, asynchronously: state IDLE, Out = 0, Out_Valid = 0, Select = 0, Last_Grant = 1, Ack_0 = Ack_1 = 0.
REQ-029 Reset asserted mid-transfer SHALL discard the captured word with no Ack; the first grant after release SHALL favour requester 0 on a tie.
REQ-030 Deassertion of Reset_n SHALL take effect at the first subsequent rising edge; no grant on that edge is required.

Verification
REQ-031 Post-reset tie: Req_0 = Req_1 = 1, In_0 = 4'hA, In_1 = 4'h5, Out_Ready = 1 -> Out = 4'hA / Select = 0 / Ack_0 one cycle, then Out = 4'h5 / Select = 1 / Ack_1 on the next cycle, alternating thereafter.
REQ-032 Single requester: Req_1 = 1 only, In_1 = 4'h3, Out_Ready = 1 -> Out_Valid pattern 1,0,1,0 and Ack_1 high in each valid cycle.
REQ-033 Stall: grant In_0 = 4'hC with Out_Ready = 0 for 5 cycles while In_0 changes to 4'h1 -> Out stays 4'hC, Ack_0 = 0; Out_Ready = 1 -> Ack_0 pulses once.
REQ-034 Withdrawal: Req_0 drops one cycle after grant with Out_Ready = 0 -> Out_Valid stays 1; later Out_Ready = 1 -> Ack_0 = 1, then IDLE.
REQ-035 Reset mid-transfer: Reset_n = 0 during BUSY1 -> Out = 0, Out_Valid = 0, Select = 0, no Ack; after release, a tie grants requester 0 first.
REQ-036 Exhaustive data: for all 16x16 In_0/In_1 pairs, each granted word SHALL equal the granted requester's data at the grant edge.
